// File: rtl/uart_rx_sequencer_pkg.sv
// Shared definitions for the serial receive path: sequencer state encoding and default framing.
// The future transmit sequencer reuses the same encodings.
package uart_rx_sequencer_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

endpackage

// File: rtl/uart_sample_timer.sv
// Oversample phase counter for the receive sequencer: counts clk cycles within a serial bit and
// flags the half-bit and full-bit sample points.
module uart_sample_timer
    import uart_rx_sequencer_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic halfTc,
    output logic fullTc
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] sampleCnt_r;

    assign halfTc = (sampleCnt_r == HALF_LAST);
    assign fullTc = (sampleCnt_r == FULL_LAST);

    // Phase counter: held at zero while cleared, wraps after the last cycle of a bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sampleCnt_r <= {CNT_W{1'b0}};
        end else if (clear || fullTc) begin
            sampleCnt_r <= {CNT_W{1'b0}};
        end else begin
            sampleCnt_r <= sampleCnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_sequencer.sv
// Receive-side framing sequencer: synchronises the serial pin, times start/data/stop sampling from
// the oversample timer and hands completed characters to the consumer with a valid/ack handshake.
module uart_rx_sequencer
    import uart_rx_sequencer_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serialIn,
    input  logic                 rxEnable,
    input  logic                 charAck,
    output logic [DATA_BITS-1:0] charData,
    output logic                 charValid,
    output logic                 framingError,
    output logic                 overrun
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    rxState_t             state_r;
    logic                 rxMeta_r;
    logic                 rxS_r;
    logic [BIT_W-1:0]     bitCnt_r;
    logic [DATA_BITS-1:0] shiftReg_r;
    logic                 timerClear_s;
    logic                 halfTc_s;
    logic                 fullTc_s;

    // Data arrives LSB-first, so each new bit enters at the top and earlier bits move down.
    function automatic logic [DATA_BITS-1:0] shiftInMsb(input logic [DATA_BITS-1:0] sr,
                                                         input logic bitIn);
        logic [DATA_BITS-1:0] res;
        res = sr >> 1;
        res[DATA_BITS-1] = bitIn;
        return res;
    endfunction

    uart_sample_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) sampleTimer (
        .clk   (clk),
        .reset (reset),
        .clear (timerClear_s),
        .halfTc(halfTc_s),
        .fullTc(fullTc_s)
    );

    // Timer restarts its bit phase while idle/disarmed and when the start bit centre is reached.
    always_comb begin
        timerClear_s = 1'b0;
        if (state_r == IDLE || !rxEnable) begin
            timerClear_s = 1'b1;
        end else if (state_r == START && halfTc_s) begin
            timerClear_s = 1'b1;
        end else begin
            timerClear_s = 1'b0;
        end
    end

    // Two-flop synchroniser on the raw serial pin; idles high like the line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxMeta_r <= 1'b1;
            rxS_r    <= 1'b1;
        end else begin
            rxMeta_r <= serialIn;
            rxS_r    <= rxMeta_r;
        end
    end

    // Framing FSM with bit counter, shift register and consumer handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            bitCnt_r     <= {BIT_W{1'b0}};
            shiftReg_r   <= {DATA_BITS{1'b0}};
            charData     <= {DATA_BITS{1'b0}};
            charValid    <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            framingError <= 1'b0;
            if (charAck && charValid) begin
                charValid <= 1'b0;
                overrun   <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (rxEnable && !rxS_r) begin
                        state_r <= START;
                    end
                end
                START: begin
                    if (!rxEnable) begin
                        state_r <= IDLE;
                    end else if (halfTc_s) begin
                        if (!rxS_r) begin
                            state_r  <= DATA;
                            bitCnt_r <= {BIT_W{1'b0}};
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (!rxEnable) begin
                        state_r <= IDLE;
                    end else if (fullTc_s) begin
                        shiftReg_r <= shiftInMsb(shiftReg_r, rxS_r);
                        bitCnt_r   <= bitCnt_r + BIT_W'(1);
                        if (bitCnt_r == LAST_BIT) begin
                            state_r <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                    if (!rxEnable) begin
                        state_r <= IDLE;
                    end else if (fullTc_s) begin
                        state_r <= IDLE;
                        if (rxS_r) begin
                            charData  <= shiftReg_r;
                            charValid <= 1'b1;
                            if (charValid && !charAck) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framingError <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: directed framing scenarios plus randomized traffic,
// compared every cycle against a timeline model of the received line.
module tb_uart_rx_sequencer;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int START_OFF = OS / 2;
    localparam int STOP_OFF  = OS / 2 + (DB + 1) * OS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serialIn = 1'b1;
    logic       rxEnable = 1'b0;
    logic       charAck = 1'b0;
    logic [7:0] charData;
    logic       charValid;
    logic       framingError;
    logic       overrun;

    uart_rx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .serialIn    (serialIn),
        .rxEnable    (rxEnable),
        .charAck     (charAck),
        .charData    (charData),
        .charValid   (charValid),
        .framingError(framingError),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Model: the line history plus the edge at which the current frame's start was seen.
    bit         hist [0:99999];
    int         edgeIdx = 0;
    int         lastReset = -1;
    bit         mBusy = 1'b0;
    int         mStart = 0;
    logic [7:0] mAcc = 8'h00;
    logic [7:0] mCd = 8'h00;
    bit         mCv = 1'b0;
    bit         mFe = 1'b0;
    bit         mOv = 1'b0;

    bit checking = 1'b0;
    int nChecks = 0;
    int nPass = 0;
    int feSeen = 0;
    int cvSeen = 0;
    int ackPct = 0;
    int dropPermille = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // One clock edge of the model; the line seen by the receiver is the pin two edges earlier.
    task automatic modelStep();
        int  rxs;
        int  off;
        bit  cvBefore;
        hist[edgeIdx] = serialIn;
        if (!reset) begin
            mBusy = 1'b0; mCd = 8'h00; mCv = 1'b0; mFe = 1'b0; mOv = 1'b0;
            lastReset = edgeIdx;
        end else begin
            rxs = (edgeIdx - 2 > lastReset) ? int'(hist[edgeIdx - 2]) : 1;
            mFe = 1'b0;
            cvBefore = mCv;
            if (charAck && mCv) begin
                mCv = 1'b0; mOv = 1'b0;
            end
            if (!mBusy) begin
                if (rxEnable && rxs == 0) begin
                    mBusy = 1'b1; mStart = edgeIdx;
                end
            end else begin
                off = edgeIdx - mStart;
                if (!rxEnable) mBusy = 1'b0;
                else if (off == START_OFF) begin
                    if (rxs == 1) mBusy = 1'b0;
                end else if (off == STOP_OFF) begin
                    mBusy = 1'b0;
                    if (rxs == 1) begin
                        if (cvBefore && !charAck) mOv = 1'b1;
                        mCd = mAcc; mCv = 1'b1;
                    end else mFe = 1'b1;
                end else if (off > START_OFF && (off - START_OFF) % OS == 0)
                    mAcc[(off - START_OFF) / OS - 1] = rxs[0];
            end
        end
        edgeIdx++;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        checking = 1'b1;
        @(negedge clk);
        if (framingError === 1'b1) feSeen++;
        if (charValid === 1'b1) cvSeen++;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("charData", 32'(charData), 32'(mCd));
            chk("charValid", 32'(charValid), 32'(mCv));
            chk("framingError", 32'(framingError), 32'(mFe));
            chk("overrun", 32'(overrun), 32'(mOv));
        end
    end

    task automatic drive(input bit line, input bit en, input bit rst);
        serialIn = line;
        rxEnable = en && !($urandom_range(999) < dropPermille);
        reset    = rst;
        charAck  = ($urandom_range(99) < ackPct);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1);
    endtask

    task automatic ackOnce();
        serialIn = 1'b1; rxEnable = 1'b1; reset = 1'b1; charAck = 1'b1;
        tick();
        charAck = 1'b0;
    endtask

    // Full frame, 16 clk per bit; optional cut (line forced high), reset pulse, disarm pulse.
    task automatic sendFrame(input logic [7:0] d, input bit stopBit, input int cutAt,
                             input int rstAt, input int disAt);
        bit line;
        for (int idx = 0; idx < 10 * OS; idx++) begin
            if (idx < OS) line = 1'b0;
            else if (idx < 9 * OS) line = d[(idx - OS) / OS];
            else line = stopBit;
            if (cutAt >= 0 && idx >= cutAt) line = 1'b1;
            drive(line, idx != disAt, idx != rstAt);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        chk("rstData", 32'(charData), 32'h0);
        chk("rstValid", 32'(charValid), 32'h0);
        chk("rstOverrun", 32'(overrun), 32'h0);
        idle(5);

        feSeen = 0;
        sendFrame(8'hA5, 1'b1, -1, -1, -1);
        idle(10);
        chk("a5Data", 32'(charData), 32'hA5);
        chk("a5Model", 32'(mCd), 32'hA5);
        chk("a5Valid", 32'(charValid), 32'h1);
        chk("a5NoFe", 32'(feSeen), 32'h0);
        ackOnce();
        chk("a5Acked", 32'(charValid), 32'h0);

        cvSeen = 0; feSeen = 0;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1);
        idle(40);
        chk("glitchNoChar", 32'(cvSeen), 32'h0);
        chk("glitchNoFe", 32'(feSeen), 32'h0);

        cvSeen = 0; feSeen = 0;
        sendFrame(8'h3C, 1'b0, -1, -1, -1);
        idle(10);
        chk("feOnePulse", 32'(feSeen), 32'h1);
        chk("feNoChar", 32'(cvSeen), 32'h0);
        chk("feDataKept", 32'(charData), 32'hA5);

        sendFrame(8'h11, 1'b1, -1, -1, -1);
        sendFrame(8'h22, 1'b1, -1, -1, -1);
        idle(10);
        chk("ovrData", 32'(charData), 32'h22);
        chk("ovrValid", 32'(charValid), 32'h1);
        chk("ovrSet", 32'(overrun), 32'h1);
        chk("ovrModel", 32'(mOv), 32'h1);
        ackOnce();
        chk("ovrAckValid", 32'(charValid), 32'h0);
        chk("ovrAckClr", 32'(overrun), 32'h0);

        sendFrame(8'h55, 1'b1, 60, 60, -1);
        idle(10);
        chk("midRstData", 32'(charData), 32'h0);
        chk("midRstValid", 32'(charValid), 32'h0);
        sendFrame(8'h0F, 1'b1, -1, -1, -1);
        idle(10);
        chk("afterRstData", 32'(charData), 32'h0F);
        ackOnce();

        cvSeen = 0;
        sendFrame(8'h99, 1'b1, 73, -1, 72);
        idle(20);
        chk("disarmNoChar", 32'(cvSeen), 32'h0);
        sendFrame(8'h81, 1'b1, -1, -1, -1);
        idle(10);
        chk("rearmData", 32'(charData), 32'h81);
        chk("rearmModel", 32'(mCd), 32'h81);
        ackOnce();

        ackPct = 10;
        dropPermille = 2;
        for (int f = 0; f < 40; f++) begin
            int r;
            r = int'($urandom_range(9));
            if (r == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 7)); i++) drive(1'b0, 1'b1, 1'b1);
            end else if (r == 1) begin
                sendFrame(8'($urandom), 1'b1, -1, int'($urandom_range(20, 150)), -1);
            end else begin
                sendFrame(8'($urandom), $urandom_range(9) != 0, -1, -1, -1);
            end
            idle(int'($urandom_range(0, 30)));
        end
        ackPct = 0;
        dropPermille = 0;
        idle(200);

        checking = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
